loba_lod_pipe: RTL and testbench
================================

LOBA_LOD_PIPE -- requirements
Module: loba_lod_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; legal range WIDTH >= 2.
REQ-002 Parameter KEEP, default 6: fragment width kept from the leading one downward; legal range 2 <= KEEP <= WIDTH.
REQ-003 Derived constant PW = $clog2(WIDTH): width of the pos and shift fields.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 in_valid  in  1  in_x carries a valid operand.
REQ-007 in_ready  out  1  block accepts in_x this cycle.
REQ-008 in_x  in  WIDTH  unsigned operand.
REQ-009 out_valid  out  1  result fields are valid.
REQ-010 out_ready  in  1  downstream accepts the result this cycle.
REQ-011 out_onehot  out  WIDTH  one-hot leading-one mask; all zeros when in_x = 0.
REQ-012 out_pos  out  PW  binary index of the leading one; 0 when in_x = 0.
REQ-013 out_zero  out  1  high when in_x = 0.
REQ-014 out_frag  out  KEEP  approximated operand fragment.
REQ-015 out_shift  out  PW  left-shift that restores the fragment's magnitude.

Function
REQ-016 Transfers: input on in_valid && in_ready; output on out_valid && out_ready.
REQ-017 Two register stages. S1 holds the operand; S2 holds the computed result, which drives all out_* ports directly.
REQ-018 Latency: an operand accepted at edge N is presented with out_valid = 1 after edge N+1, provided S2 is free. Latency is 2 stages, and a new transfer can complete every cycle.
REQ-019 Stage advance rule:
- S2 loads when S1 is valid and (S2 is empty or out_ready = 1).
- S1 loads when in_valid and in_ready are both 1.
REQ-020 in_ready = !s1_valid || !s2_valid || out_ready. This is a combinational path from out_ready, and it is permitted.
REQ-021 While out_valid = 1 and out_ready = 0, all out_* fields hold stable. No operand is dropped or duplicated.
REQ-022 Leading-one detection is a priority search that starts at bit WIDTH-1. out_onehot has exactly one bit set, at out_pos.
REQ-023 When out_pos >= KEEP-1:
- out_frag = x[pos:pos-KEEP+1].
- out_shift = pos-KEEP+1.
REQ-024 When out_pos < KEEP-1, or x = 0:
- out_frag = x[KEEP-1:0], which is exact.
- out_shift = 0.
REQ-025 Invariant: out_frag << out_shift <= x, with equality whenever the dropped bits are zero (unbias feature off).

Reset
REQ-026 With rst high at an edge:
- S1 and S2 valid flags clear.
- out_valid = 0 and in_ready = 1 on the next cycle.
- Data fields reset to 0.
REQ-027 A reset asserted mid-operation discards every in-flight operand. An input presented in the same cycle as rst is not accepted.

Configuration
REQ-028 Macro LOBA_LOD_UNBIAS_EN selects the fragment bias correction.
- Defined: when out_shift > 0, out_frag[0] is forced to 1 (mean truncation error correction). When out_shift = 0, out_frag is unchanged.
- Undefined: out_frag is plain truncation per REQ-023/024.
- Handshake and timing are identical in both builds.

Structure
REQ-029 Package loba_pkg holds:
- the PW derivation function;
- the result struct typedef (onehot, pos, zero, frag, shift);
- the default WIDTH and KEEP constants.
REQ-030 Sub-module loba_lob_enc is a combinational, parametrised priority encoder producing onehot, pos and zero. loba_lod_pipe instantiates it between S1 and S2.

Verification (WIDTH=16, KEEP=6)
REQ-031 in_x = 0x0000 -> out_zero = 1, out_onehot = 0x0000, out_pos = 0, out_frag = 0x00, out_shift = 0.
REQ-032 in_x = 0x8001 -> onehot = 0x8000, pos = 15, shift = 10, frag = 0x20. With LOBA_LOD_UNBIAS_EN defined, frag = 0x21.
REQ-033 in_x = 0x1234 -> pos = 12, shift = 7, frag = 0x24 (0x25 with unbias). in_x = 0x0013 -> pos = 4, shift = 0, frag = 0x13 in both builds.
REQ-034 Back-to-back 0x0001, 0x002B, 0xFFFF with out_ready = 1 -> three results on consecutive cycles:
- 0x0001: pos = 0, frag = 0x01.
- 0x002B: pos = 5, frag = 0x2B.
- 0xFFFF: pos = 15, frag = 0x3F (0x3F with unbias).
- First result appears one cycle after the first acceptance.
REQ-035 Backpressure: out_ready = 0 for 4 cycles while in_valid stays high.
- in_ready falls after two operands are accepted.
- Outputs stay stable throughout the stall.
- On release, results drain in order with none lost.
REQ-036 Reset with both stages full -> out_valid = 0 and in_ready = 1 on the next cycle. No stale result appears afterwards.

Source files
------------

// File: rtl/loba_pkg.sv
// Shared constants, PW derivation and default-configuration result layout for the LOBA leading-one pipeline.
// Combinational helpers only; no latency, no flow control.
package loba_pkg;

  localparam int LOBA_WIDTH = 16;
  localparam int LOBA_KEEP  = 6;

  // A 1-bit field is still needed when WIDTH collapses $clog2 to 0.
  function automatic int loba_pw(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int LOBA_PW = loba_pw(LOBA_WIDTH);

  typedef struct packed {
    logic [LOBA_WIDTH-1:0] onehot;
    logic [LOBA_PW-1:0]    pos;
    logic                  zero;
    logic [LOBA_KEEP-1:0]  frag;
    logic [LOBA_PW-1:0]    shift;
  } loba_res_t;

endpackage

// File: rtl/loba_lob_enc.sv
// Priority leading-one encoder: one-hot mask, binary index and zero flag.
// Purely combinational; no latency, no flow control.
module loba_lob_enc
  import loba_pkg::*;
#(
  parameter int WIDTH = LOBA_WIDTH,
  localparam int PW   = loba_pw(WIDTH)
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] onehot_o,
  output logic [PW-1:0]    pos_o,
  output logic             zero_o
);

  logic found;

  always_comb begin
    onehot_o = '0;
    pos_o    = '0;
    found    = 1'b0;
    zero_o   = (x_i == '0);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && x_i[i]) begin
        found       = 1'b1;
        pos_o       = PW'(i);
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/loba_lod_pipe.sv
// Two-stage leading-one detect + KEEP-bit fragment extraction; result appears one edge after S1 loads.
// Valid/ready with full-throughput skid-free stalling; LOBA_LOD_UNBIAS_EN forces frag LSB when bits were dropped.
module loba_lod_pipe
  import loba_pkg::*;
#(
  parameter int WIDTH = LOBA_WIDTH,
  parameter int KEEP  = LOBA_KEEP,
  localparam int PW   = loba_pw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [PW-1:0]    out_pos,
  output logic             out_zero,
  output logic [KEEP-1:0]  out_frag,
  output logic [PW-1:0]    out_shift
);

  typedef struct packed {
    logic [WIDTH-1:0] onehot;
    logic [PW-1:0]    pos;
    logic             zero;
    logic [KEEP-1:0]  frag;
    logic [PW-1:0]    shift;
  } res_t;

  localparam logic [PW-1:0] KEEP_M1 = PW'(KEEP - 1);

  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_x_q;
  logic             s2_vld_q, s2_vld_d;
  res_t             s2_res_q, res_d;

  logic             in_fire, out_fire, s2_load;
  logic [WIDTH-1:0] enc_onehot;
  logic [PW-1:0]    enc_pos;
  logic             enc_zero;

  assign in_ready = !s1_vld_q || !s2_vld_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_vld_q && out_ready;
  assign s2_load  = s1_vld_q && (!s2_vld_q || out_ready);

  loba_lob_enc #(.WIDTH(WIDTH)) u_enc (
    .x_i      (s1_x_q),
    .onehot_o (enc_onehot),
    .pos_o    (enc_pos),
    .zero_o   (enc_zero)
  );

  always_comb begin
    res_d        = '0;
    res_d.onehot = enc_onehot;
    res_d.pos    = enc_pos;
    res_d.zero   = enc_zero;
    if (!enc_zero && (enc_pos >= KEEP_M1)) begin
      res_d.shift = enc_pos - KEEP_M1;
    end
    // With shift = 0 this is simply x[KEEP-1:0], which is exact below KEEP bits.
    res_d.frag = KEEP'(s1_x_q >> res_d.shift);
`ifdef LOBA_LOD_UNBIAS_EN
    if (res_d.shift != '0) begin
      res_d.frag[0] = 1'b1;
    end
`endif
  end

  always_comb begin
    s1_vld_d = s1_vld_q;
    if (in_fire) begin
      s1_vld_d = 1'b1;
    end else if (s2_load) begin
      s1_vld_d = 1'b0;
    end
    s2_vld_d = s2_vld_q;
    if (s2_load) begin
      s2_vld_d = 1'b1;
    end else if (out_fire) begin
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_x_q   <= '0;
      s2_vld_q <= 1'b0;
      s2_res_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      if (in_fire) begin
        s1_x_q <= in_x;
      end
      if (s2_load) begin
        s2_res_q <= res_d;
      end
    end
  end

  assign out_valid  = s2_vld_q;
  assign out_onehot = s2_res_q.onehot;
  assign out_pos    = s2_res_q.pos;
  assign out_zero   = s2_res_q.zero;
  assign out_frag   = s2_res_q.frag;
  assign out_shift  = s2_res_q.shift;

endmodule

// File: tb/tb_loba_lod_pipe.sv
// Bench for loba_lod_pipe at WIDTH=16, KEEP=6: directed vectors plus an arithmetic reference model and scoreboard.
module tb_loba_lod_pipe;

  localparam int K = 6;

  typedef logic [30:0] pack_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_onehot;
  logic [3:0]  out_pos;
  logic        out_zero;
  logic [5:0]  out_frag;
  logic [3:0]  out_shift;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  pack_t       dut_pack;
  pack_t       snap;

  loba_lod_pipe #(.WIDTH(16), .KEEP(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_pos    (out_pos),
    .out_zero   (out_zero),
    .out_frag   (out_frag),
    .out_shift  (out_shift)
  );

  always #5 clk = ~clk;

  assign dut_pack = {out_onehot, out_pos, out_zero, out_frag, out_shift};

  // Leading-one index by repeated shifting; fragment by plain division by 2^shift.
  function automatic pack_t model(input logic [15:0] x);
    int          p;
    int          sh;
    logic [5:0]  fr;
    logic [15:0] oh;
    p = 0;
    while (p < 15 && (x >> (p + 1)) != 16'h0) p++;
    sh = (x != 16'h0 && p >= K - 1) ? p - K + 1 : 0;
    fr = 6'((x >> sh) & 16'h003F);
`ifdef LOBA_LOD_UNBIAS_EN
    if (sh > 0) fr[0] = 1'b1;
`endif
    oh = (x == 16'h0) ? 16'h0 : (16'h1 << p);
    return {oh, 4'(p), (x == 16'h0), fr, 4'(sh)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stale_out: got out_valid=1 with pack 0x%0h, expected no result", dut_pack);
        end else begin
          chk("model", 32'(dut_pack), 32'(model(exp_q[0])));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_x);
    end
  end

  // Enters and leaves just after a rising edge with the pipe empty.
  task automatic send_check(input logic [15:0] x, input logic [15:0] oh, input logic [3:0] pos,
                            input logic zero, input logic [5:0] frag, input logic [3:0] sh);
    in_valid  = 1'b1;
    in_x      = x;
    out_ready = 1'b1;
    @(negedge clk);
    chk("single_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("single_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_onehot", 32'(out_onehot), 32'(oh));
    chk("single_pos", 32'(out_pos), 32'(pos));
    chk("single_zero", 32'(out_zero), 32'(zero));
    chk("single_frag", 32'(out_frag), 32'(frag));
    chk("single_shift", 32'(out_shift), 32'(sh));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 30) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d results pending, expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = 16'h0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_fields", 32'(dut_pack), 32'd0);
    @(posedge clk); #1;

    send_check(16'h0000, 16'h0000, 4'd0, 1'b1, 6'h00, 4'd0);
`ifdef LOBA_LOD_UNBIAS_EN
    send_check(16'h8001, 16'h8000, 4'd15, 1'b0, 6'h21, 4'd10);
    send_check(16'h1234, 16'h1000, 4'd12, 1'b0, 6'h25, 4'd7);
`else
    send_check(16'h8001, 16'h8000, 4'd15, 1'b0, 6'h20, 4'd10);
    send_check(16'h1234, 16'h1000, 4'd12, 1'b0, 6'h24, 4'd7);
`endif
    send_check(16'h0013, 16'h0010, 4'd4, 1'b0, 6'h13, 4'd0);

    // Back-to-back stream with the sink always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_x      = 16'h0001;
    @(posedge clk); #1;
    in_x = 16'h002B;
    @(negedge clk);
    chk("b2b_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_x = 16'hFFFF;
    @(negedge clk);
    chk("b2b_r0_valid", 32'(out_valid), 32'd1);
    chk("b2b_r0_pos", 32'(out_pos), 32'd0);
    chk("b2b_r0_frag", 32'(out_frag), 32'h01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_r1_valid", 32'(out_valid), 32'd1);
    chk("b2b_r1_pos", 32'(out_pos), 32'd5);
    chk("b2b_r1_frag", 32'(out_frag), 32'h2B);
    @(negedge clk);
    chk("b2b_r2_valid", 32'(out_valid), 32'd1);
    chk("b2b_r2_pos", 32'(out_pos), 32'd15);
    chk("b2b_r2_frag", 32'(out_frag), 32'h3F);
    @(negedge clk);
    chk("b2b_empty", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Backpressure: sink stalls for four cycles while the source keeps offering.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = 16'h0A55;
    @(negedge clk);
    chk("bp_ready_first", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_x = 16'h3C3C;
    @(negedge clk);
    chk("bp_ready_second", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_x = 16'h00F0;
    @(negedge clk);
    chk("bp_ready_fall", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head_pos", 32'(out_pos), 32'd11);
    snap = dut_pack;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stable", 32'(dut_pack), 32'(snap));
      chk("bp_ready_low", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_x = 16'h7001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("bp_drain");
    chk("bp_all_drained", 32'(exp_q.size()), 32'd0);

    // Reset with both stages occupied; the operand offered alongside rst must vanish.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = 16'h4000;
    @(posedge clk); #1;
    in_x = 16'h0800;
    @(posedge clk); #1;
    rst  = 1'b1;
    in_x = 16'h0111;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_mid_no_stale", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Mixed operands through the scoreboard after recovery from reset.
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      in_x      = 16'(16'h0037 << i) ^ 16'(i);
      out_ready = (i % 3) != 2;
      @(posedge clk); #1;
      while (!in_ready) begin
        out_ready = 1'b1;
        @(posedge clk); #1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("mix_drain");
    chk("mix_all_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
